// File: rtl/seg7_bcd_scan_ctrl.sv
// seg7_bcd_scan_ctrl
// Takes a 14-bit binary value over a VALID/READY handshake and converts it to
// four BCD digits with a bit-serial double-dabble engine. It then drives a
// common-anode 4-digit 7-segment display by time-multiplexing the digits. The
// display supports optional leading-zero blanking and shows dashes when the
// value does not fit in four digits.

module seg7_bcd_scan_ctrl #(
    parameter int PRESCALE = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        BIN_VALID,
    input  logic [13:0] BIN,
    output logic        BIN_READY,
    output logic        OVF,
    output logic [6:0]  SEG7OUT,
    output logic [3:0]  SEG7COM
);

    localparam int              PW         = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [3:0]      DIGIT_DASH = 4'hE;
    localparam logic [13:0]     MAX_SHOWN  = 14'd9999;
    localparam logic [3:0]      NUM_BITS   = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // Segment patterns are active-low, bit6=g .. bit0=a. The internal dash
    // code lives outside the BCD range so it cannot be confused with a digit.
    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        case (d)
            4'd0:       decode_digit = 7'h40;
            4'd1:       decode_digit = 7'h79;
            4'd2:       decode_digit = 7'h24;
            4'd3:       decode_digit = 7'h30;
            4'd4:       decode_digit = 7'h19;
            4'd5:       decode_digit = 7'h12;
            4'd6:       decode_digit = 7'h02;
            4'd7:       decode_digit = 7'h78;
            4'd8:       decode_digit = 7'h00;
            4'd9:       decode_digit = 7'h10;
            DIGIT_DASH: decode_digit = 7'h3F;
            default:    decode_digit = 7'h7F;
        endcase
    endfunction

    // Converter state
    state_t            state_q, state_d;
    logic [13:0]       shift_q, shift_d;
    logic [15:0]       bcd_q, bcd_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              big_q, big_d;
    logic              ready_q, ready_d;
    logic              ovf_q, ovf_d;
    logic [3:0][3:0]   digit_q, digit_d;
    logic [15:0]       bcd_adj;

    // Scanner state
    logic [PW-1:0]     presc_q, presc_d;
    logic [1:0]        idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        com_q, com_d;
    logic [3:0]        cur_digit;
    logic              zero_3, zero_32, zero_321;
    logic              blank_now;

    // Double-dabble correction: any nibble of 5 or more gets +3 before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Converter sequencing: capture on handshake, 14 shift cycles, then one latch cycle
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        big_d   = big_q;
        ready_d = ready_q;
        ovf_d   = ovf_q;
        digit_d = digit_q;
        case (state_q)
            ST_IDLE: begin
                if (BIN_VALID && ready_q) begin
                    shift_d = BIN;
                    bcd_d   = 16'h0000;
                    cnt_d   = NUM_BITS;
                    big_d   = (BIN > MAX_SHOWN);
                    ready_d = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d   = {bcd_adj[14:0], shift_q[13]};
                shift_d = {shift_q[12:0], 1'b0};
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (big_q) begin
                    ovf_d   = 1'b1;
                    digit_d = {4{DIGIT_DASH}};
                end else begin
                    ovf_d   = 1'b0;
                    digit_d = bcd_q;
                end
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Converter and display registers; reset abandons any conversion in flight
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            big_q   <= 1'b0;
            ready_q <= 1'b1;
            ovf_q   <= 1'b0;
            digit_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            big_q   <= big_d;
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
            digit_q <= digit_d;
        end
    end

    // A digit is a leading zero when it and every higher digit are zero
    always_comb begin
        zero_3   = (digit_q[3] == 4'd0);
        zero_32  = zero_3  && (digit_q[2] == 4'd0);
        zero_321 = zero_32 && (digit_q[1] == 4'd0);
    end

    // Scanner: prescaler steps the digit index, outputs follow the index one cycle later
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
        com_d     = ~(4'b0001 << idx_q);
        cur_digit = digit_q[idx_q];
        case (idx_q)
            2'd1:    blank_now = zero_321;
            2'd2:    blank_now = zero_32;
            2'd3:    blank_now = zero_3;
            default: blank_now = 1'b0;
        endcase
        if (BLANK_LZ && !ovf_q && blank_now) begin
            seg_d = 7'h7F;
        end else begin
            seg_d = decode_digit(cur_digit);
        end
    end

    // Scanner and pin registers; pins are dark until the first scan cycle
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            seg_q   <= 7'h7F;
            com_q   <= 4'b1111;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            com_q   <= com_d;
        end
    end

    assign BIN_READY = ready_q;
    assign OVF       = ovf_q;
    assign SEG7OUT   = seg_q;
    assign SEG7COM   = com_q;

endmodule

// File: tb/tb_seg7_bcd_scan_ctrl.sv
// tb_seg7_bcd_scan_ctrl
// Bench for the BCD converter / display scanner. Two instances share stimulus:
// one blanks leading zeros and one shows all digits. A scoreboard queue holds
// the values handed to the converter. A negedge monitor pops an entry when
// BIN_READY returns. It then compares every scanned digit with an arithmetic
// model of what the display should show.

module tb_seg7_bcd_scan_ctrl;

    localparam int PRESCALE = 4;

    typedef struct {
        int value;
        int hs;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        BIN_VALID = 1'b0;
    logic [13:0] BIN = 14'd0;

    logic        ready_b, ovf_b, ready_f, ovf_f;
    logic [6:0]  seg_b, seg_f;
    logic [3:0]  com_b, com_f;

    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    int   since_rst = 0;
    exp_t sb[$];

    int   model_val = 0;
    bit   model_ovf = 1'b0;
    bit   staged = 1'b0;
    int   staged_val = 0;
    bit   ready_prev = 1'b1;

    seg7_bcd_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK_LZ(1'b1)) dut_blank (
        .CLK(CLK), .RSTn(RSTn), .BIN_VALID(BIN_VALID), .BIN(BIN),
        .BIN_READY(ready_b), .OVF(ovf_b), .SEG7OUT(seg_b), .SEG7COM(com_b)
    );

    seg7_bcd_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK_LZ(1'b0)) dut_full (
        .CLK(CLK), .RSTn(RSTn), .BIN_VALID(BIN_VALID), .BIN(BIN),
        .BIN_READY(ready_f), .OVF(ovf_f), .SEG7OUT(seg_f), .SEG7COM(com_f)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    // Cycle counters: absolute edge count and edges since reset release
    always @(posedge CLK) cycle <= cycle + 1;

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) since_rst <= 0;
        else       since_rst <= since_rst + 1;
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    // What digit k of the display should show for value v
    function automatic logic [6:0] expSeg(input int v, input int k, input bit blank);
        int p;
        int d;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (v > 9999) return 7'h3F;
        if (blank && k > 0 && v < p) return 7'h7F;
        d = (v / p) % 10;
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Monitor: checks the scan pattern every cycle and retires conversions
    always @(negedge CLK) begin
        int idx;
        logic [3:0] exp_com;
        logic [6:0] exp_sb, exp_sf;
        exp_t e;
        if (!RSTn) begin
            checkOutput("rst_ready_b", 16'(ready_b), 16'd1);
            checkOutput("rst_ready_f", 16'(ready_f), 16'd1);
            checkOutput("rst_ovf", 16'(ovf_b), 16'd0);
            checkOutput("rst_com", 16'(com_b), 16'hF);
            checkOutput("rst_seg_b", 16'(seg_b), 16'h7F);
            checkOutput("rst_seg_f", 16'(seg_f), 16'h7F);
            model_val  = 0;
            model_ovf  = 1'b0;
            staged     = 1'b0;
            ready_prev = 1'b1;
        end else begin
            if (staged) begin
                model_val = staged_val;
                staged    = 1'b0;
            end
            if (since_rst == 0) begin
                exp_com = 4'hF;
                exp_sb  = 7'h7F;
                exp_sf  = 7'h7F;
            end else begin
                idx     = ((since_rst - 1) / PRESCALE) % 4;
                exp_com = 4'hF ^ (4'h1 << idx);
                exp_sb  = expSeg(model_val, idx, 1'b1);
                exp_sf  = expSeg(model_val, idx, 1'b0);
            end
            checkOutput("com_b", 16'(com_b), 16'(exp_com));
            checkOutput("com_f", 16'(com_f), 16'(exp_com));
            checkOutput("seg_blank", 16'(seg_b), 16'(exp_sb));
            checkOutput("seg_full", 16'(seg_f), 16'(exp_sf));
            if (ready_b && !ready_prev) begin
                checkOutput("ready_f_done", 16'(ready_f), 16'd1);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 16'(sb.size()), 16'd1);
                end else begin
                    e = sb.pop_front();
                    checkOutput("latency", 16'(cycle - e.hs), 16'd15);
                    model_ovf  = (e.value > 9999);
                    staged_val = e.value;
                    staged     = 1'b1;
                end
            end
            checkOutput("ovf_b", 16'(ovf_b), 16'(model_ovf));
            checkOutput("ovf_f", 16'(ovf_f), 16'(model_ovf));
            ready_prev = ready_b;
        end
    end

    // Present one value, wait for acceptance, then scramble BIN behind it
    task automatic applyStimulus(input int v);
        int w;
        w = 0;
        @(negedge CLK);
        BIN       = 14'(v);
        BIN_VALID = 1'b1;
        while (!ready_b && w < 60) begin
            @(negedge CLK);
            w++;
        end
        if (!ready_b) begin
            checkOutput("accept_timeout", 16'(ready_b), 16'd1);
            BIN_VALID = 1'b0;
            return;
        end
        sb.push_back('{v, cycle + 1});
        @(negedge CLK);
        BIN_VALID = 1'b0;
        BIN       = 14'($urandom);
    endtask

    // Wait for the converter to finish, then let a full scan go by
    task automatic settle();
        int w;
        w = 0;
        while (!ready_b && w < 40) begin
            @(negedge CLK);
            w++;
        end
        checkOutput("settle_ready", 16'(ready_b), 16'd1);
        repeat (4 * PRESCALE + 2) @(negedge CLK);
    endtask

    initial begin
        int hs1, hs2, v, w;
        bit got;

        // Power-up reset, released just after an edge so the dark cycle is seen
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #1 RSTn = 1'b1;
        repeat (20) @(negedge CLK);

        // Directed values: digits, short value, overflow boundary, back to zero
        applyStimulus(1234);  settle();
        applyStimulus(7);     settle();
        applyStimulus(9999);  settle();
        applyStimulus(10000); settle();
        applyStimulus(16383); settle();
        applyStimulus(0);     settle();

        // VALID held across two conversions; BIN is junk while not ready
        @(negedge CLK);
        BIN       = 14'd42;
        BIN_VALID = 1'b1;
        w = 0;
        while (!ready_b && w < 40) begin
            @(negedge CLK);
            w++;
        end
        hs1 = cycle + 1;
        sb.push_back('{42, hs1});
        got = 1'b0;
        hs2 = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            if (ready_b) begin
                BIN = 14'd43;
                hs2 = cycle + 1;
                sb.push_back('{43, hs2});
                got = 1'b1;
            end else begin
                BIN = 14'($urandom);
            end
        end
        checkOutput("hs_spacing", 16'(hs2 - hs1), 16'd16);
        @(negedge CLK);
        BIN_VALID = 1'b0;
        BIN       = 14'd9;
        settle();

        // Reset in the middle of a conversion
        applyStimulus(5678);
        repeat (4) @(negedge CLK);
        #1 RSTn = 1'b0;
        sb.delete();
        #1;
        checkOutput("rst_imm_ready", 16'(ready_b), 16'd1);
        checkOutput("rst_imm_com", 16'(com_b), 16'hF);
        checkOutput("rst_imm_seg", 16'(seg_b), 16'h7F);
        checkOutput("rst_imm_ovf", 16'(ovf_b), 16'd0);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1 RSTn = 1'b1;
        repeat (20) @(negedge CLK);

        // Randomized values, biased toward the overflow edge and short numbers
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 4))
                0:       v = 9998 + int'($urandom_range(0, 2));
                1:       v = 16383;
                2:       v = int'($urandom_range(0, 99));
                default: v = int'($urandom_range(0, 16383));
            endcase
            applyStimulus(v);
            repeat ($urandom_range(0, 20)) @(negedge CLK);
        end
        settle();

        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge CLK);
            w++;
        end
        checkOutput("sb_drain", 16'(sb.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
